// File: rtl/sram_block_reader_if.sv
// Read-data stream between sram_block_reader and its consumer.
// The reader is the master: it presents rd_data/rd_valid and the consumer
// answers with rd_ready. A word moves on a cycle where rd_valid && rd_ready.
interface sram_block_reader_if;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;

  modport master (
    output rd_data,
    output rd_valid,
    input  rd_ready
  );

  modport slave (
    input  rd_data,
    input  rd_valid,
    output rd_ready
  );
endinterface

// File: rtl/sram_block_reader.sv
// sram_block_reader: fetches a run of 16-bit words from the external Ram1
// asynchronous SRAM and streams them out over a valid/ready interface.
//
// Optional feature: define READ_VERIFY_EN to check each word after the first
// against (first word + word index) and report mismatches on err_flag /
// err_count. With the macro undefined both outputs are tied to zero.
//
// Access timing: the cycle after start is accepted presents the address with
// chip enable low and OE still high (address/CE setup); OE is then low for
// WAIT_CYCLES+1 cycles and the data bus is sampled at the end of the last one.
// Following words in the burst skip the setup cycle, because the address is
// updated on the same edge that accepts the previous word.
module sram_block_reader #(
  parameter int LEN_W       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  input  logic [17:0]          start_addr,
  input  logic [LEN_W-1:0]     count,
  output logic [17:0]          Ram1Addr,
  inout  wire  [15:0]          Ram1Data,
  output logic                 Ram1OE,
  output logic                 Ram1WE,
  output logic                 Ram1EN,
  sram_block_reader_if.master  rd,
  output logic                 busy,
  output logic                 done,
  output logic                 err_flag,
  output logic [LEN_W-1:0]     err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    OUTPUT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state_reg;
  logic [LEN_W-1:0]  remain_reg;
  logic [3:0]        wait_reg;
  logic              setup_reg;
  logic [17:0]       ram_addr_reg;
  logic              oe_reg;
  logic              en_reg;
  logic [15:0]       rd_data_reg;
  logic              rd_valid_reg;
  logic              busy_reg;
  logic              done_reg;

  // The reader only ever listens on the SRAM data bus.
  assign Ram1Data    = 16'hzzzz;
  assign Ram1WE      = 1'b1;
  assign Ram1Addr    = ram_addr_reg;
  assign Ram1OE      = oe_reg;
  assign Ram1EN      = en_reg;
  assign rd.rd_data  = rd_data_reg;
  assign rd.rd_valid = rd_valid_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

  // Burst sequencer: all SRAM strobes and stream outputs are registered here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= IDLE;
      remain_reg   <= '0;
      wait_reg     <= '0;
      setup_reg    <= 1'b0;
      ram_addr_reg <= '0;
      oe_reg       <= 1'b1;
      en_reg       <= 1'b1;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            ram_addr_reg <= start_addr;
            remain_reg   <= count;
            busy_reg     <= 1'b1;
            if (count == '0) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ACCESS;
              en_reg    <= 1'b0;
              setup_reg <= 1'b1;
              wait_reg  <= '0;
            end
          end
        end
        ACCESS: begin
          if (setup_reg) begin
            setup_reg <= 1'b0;
            oe_reg    <= 1'b0;
          end else if (wait_reg == WAIT_LAST) begin
            rd_data_reg  <= Ram1Data;
            rd_valid_reg <= 1'b1;
            oe_reg       <= 1'b1;
            en_reg       <= 1'b1;
            state_reg    <= OUTPUT;
          end else begin
            wait_reg <= wait_reg + 4'd1;
          end
        end
        OUTPUT: begin
          // rd_valid is always high here, so rd_ready alone completes the handshake.
          if (rd.rd_ready) begin
            rd_valid_reg <= 1'b0;
            remain_reg   <= remain_reg - LEN_W'(1);
            if (remain_reg == LEN_W'(1)) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              ram_addr_reg <= ram_addr_reg + 18'd1;
              en_reg       <= 1'b0;
              oe_reg       <= 1'b0;
              wait_reg     <= '0;
              state_reg    <= ACCESS;
            end
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef READ_VERIFY_EN
  logic              start_accept;
  logic              handshake;
  logic [15:0]       first_word_reg;
  logic [LEN_W-1:0]  idx_reg;
  logic              err_flag_reg;
  logic [LEN_W-1:0]  err_count_reg;
  logic [15:0]       expected_word;

  assign start_accept  = (state_reg == IDLE) && start;
  assign handshake     = (state_reg == OUTPUT) && rd.rd_ready;
  assign expected_word = first_word_reg + 16'(idx_reg);
  assign err_flag      = err_flag_reg;
  assign err_count     = err_count_reg;

  // Incrementing-pattern check: word 0 sets the reference, later words must equal it plus their index.
  always_ff @(posedge CLK) begin
    if (RST) begin
      first_word_reg <= '0;
      idx_reg        <= '0;
      err_flag_reg   <= 1'b0;
      err_count_reg  <= '0;
    end else if (start_accept) begin
      idx_reg       <= '0;
      err_flag_reg  <= 1'b0;
      err_count_reg <= '0;
    end else if (handshake) begin
      idx_reg <= idx_reg + LEN_W'(1);
      if (idx_reg == '0) begin
        first_word_reg <= rd_data_reg;
      end else if (rd_data_reg != expected_word) begin
        err_flag_reg <= 1'b1;
        if (err_count_reg != '1) begin
          err_count_reg <= err_count_reg + LEN_W'(1);
        end
      end
    end
  end
`else
  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_sram_block_reader.sv
// Self-checking bench for sram_block_reader with a behavioural Ram1 model
// and a scoreboard of expected {address, data} pairs per streamed word.
`timescale 1ns/1ps
module tb_sram_block_reader;
  localparam int LEN_W       = 4;
  localparam int WAIT_CYCLES = 1;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic [17:0]       start_addr = '0;
  logic [LEN_W-1:0]  count = '0;
  logic [17:0]       Ram1Addr;
  wire  [15:0]       Ram1Data;
  logic              Ram1OE, Ram1WE, Ram1EN;
  logic              busy, done, err_flag;
  logic [LEN_W-1:0]  err_count;

  sram_block_reader_if rd_if();

  sram_block_reader #(.LEN_W(LEN_W), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .start(start), .start_addr(start_addr), .count(count),
    .Ram1Addr(Ram1Addr), .Ram1Data(Ram1Data), .Ram1OE(Ram1OE), .Ram1WE(Ram1WE),
    .Ram1EN(Ram1EN), .rd(rd_if), .busy(busy), .done(done),
    .err_flag(err_flag), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  // SRAM model: base_word at base_addr, incrementing by one per address; optional corrupt cell.
  logic [17:0] base_addr = '0;
  logic [15:0] base_word = '0;
  logic        corrupt_en = 1'b0;
  logic [17:0] corrupt_addr = '0;
  logic [17:0] addr_off;
  logic [15:0] sram_q;
  assign addr_off = Ram1Addr - base_addr;
  assign sram_q   = (corrupt_en && Ram1Addr == corrupt_addr) ? 16'hBEEF : base_word + addr_off[15:0];
  assign Ram1Data = (!Ram1OE && !Ram1EN) ? sram_q : 16'hzzzz;

  typedef struct packed {
    logic [17:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;

  // Scoreboard: every accepted word is compared with the oldest expectation.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && rd_if.rd_valid && rd_if.rd_ready) begin
      hs_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data %h addr %h, required no word", rd_if.rd_data, Ram1Addr);
      end else begin
        e = exp_q.pop_front();
        if (rd_if.rd_data !== e.data || Ram1Addr !== e.addr) begin
          errors++;
          $display("FAIL word_%0d: got data %h addr %h, required data %h addr %h",
                   hs_count, rd_if.rd_data, Ram1Addr, e.data, e.addr);
        end else begin
          $display("word %0d: addr %h data %h ok", hs_count, Ram1Addr, rd_if.rd_data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push_burst(input logic [17:0] a, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      exp_t e;
      e.addr = a + 18'(i);
      e.data = (corrupt_en && e.addr == corrupt_addr) ? 16'hBEEF : base_word + 16'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [17:0] a, input int cnt);
    start_addr = a;
    count      = LEN_W'(cnt);
    start      = 1'b1;
    @(posedge CLK); #1;
    start      = 1'b0;
  endtask

  // Runs a burst; n counts sampled cycles after the edge that takes start.
  task automatic run_burst(input logic [17:0] a, input int cnt,
                           output int n_valid, output int n_done, output int pulses,
                           output int oe_low, output int en_low);
    int n;
    push_burst(a, cnt);
    pulse_start(a, cnt);
    n = 0; n_valid = -1; n_done = -1; pulses = 0; oe_low = 0; en_low = 0;
    while (n < 400) begin
      if (rd_if.rd_valid && n_valid < 0) n_valid = n;
      if (!Ram1OE) oe_low++;
      if (!Ram1EN) en_low++;
      if (done) begin
        pulses++;
        if (n_done < 0) n_done = n;
      end
      if (n_done >= 0 && !busy) break;
      @(posedge CLK); #1;
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL burst_timeout: burst at %h did not finish in 400 cycles", a);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({Ram1OE, Ram1EN, Ram1WE, busy, done, rd_if.rd_valid, err_flag} !== 7'b1110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 1110000", {Ram1OE, Ram1EN, Ram1WE, busy, done, rd_if.rd_valid, err_flag});
    end
    checks++;
    if (Ram1Addr !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h, required 00000", Ram1Addr); end
    checks++;
    if (rd_if.rd_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h, required 0000", rd_if.rd_data); end
    checks++;
    if (err_count !== '0) begin errors++; $display("FAIL reset_errcnt: got %0d, required 0", err_count); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_burst();
    int nv, nd, pl, oe, en;
    base_addr = 18'h00010; base_word = 16'h0100; rd_if.rd_ready = 1'b1;
    run_burst(18'h00010, 10, nv, nd, pl, oe, en);
    checks++;
    if (nv != 2 + WAIT_CYCLES) begin errors++; $display("FAIL first_latency: got %0d, required %0d", nv, 2 + WAIT_CYCLES); end
    checks++;
    if (nd != 3 + WAIT_CYCLES + (WAIT_CYCLES + 2) * 9) begin
      errors++; $display("FAIL burst_length: done at %0d, required %0d", nd, 3 + WAIT_CYCLES + (WAIT_CYCLES + 2) * 9);
    end
    checks++;
    if (pl != 1) begin errors++; $display("FAIL done_pulses: got %0d, required 1", pl); end
    checks++;
    if (oe != 10 * (WAIT_CYCLES + 1)) begin errors++; $display("FAIL oe_low_cycles: got %0d, required %0d", oe, 10 * (WAIT_CYCLES + 1)); end
    @(posedge CLK); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL burst_idle: busy %b done %b, required 0 0", busy, done); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL burst_words: %0d words missing, required 0", exp_q.size()); end
  endtask

  task automatic test_zero_count();
    int nv, nd, pl, oe, en;
    run_burst(18'h00030, 0, nv, nd, pl, oe, en);
    checks++;
    if (oe != 0 || en != 0) begin errors++; $display("FAIL zero_strobes: oe_low %0d en_low %0d, required 0 0", oe, en); end
    checks++;
    if (nd != 0 || pl != 1) begin errors++; $display("FAIL zero_done: at %0d pulses %0d, required at 0 pulses 1", nd, pl); end
    checks++;
    if (nv != -1) begin errors++; $display("FAIL zero_valid: rd_valid at %0d, required never", nv); end
  endtask

  task automatic test_backpressure();
    logic [15:0] snap_d;
    logic [17:0] snap_a;
    int t;
    base_addr = 18'h00020; base_word = 16'h0200; rd_if.rd_ready = 1'b0;
    push_burst(18'h00020, 4);
    pulse_start(18'h00020, 4);
    for (int w = 0; w < 4; w++) begin
      t = 0;
      while (!rd_if.rd_valid && t < 50) begin @(posedge CLK); #1; t++; end
      checks++;
      if (t >= 50) begin errors++; $display("FAIL stall_valid_timeout: word %0d never valid", w); end
      if (w == 1) begin
        snap_d = rd_if.rd_data;
        snap_a = Ram1Addr;
        for (int c = 0; c < 5; c++) begin
          @(posedge CLK); #1;
          checks++;
          if (rd_if.rd_data !== snap_d || Ram1Addr !== snap_a || Ram1OE !== 1'b1 || rd_if.rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold_%0d: data %h addr %h oe %b valid %b, required %h %h 1 1",
                     c, rd_if.rd_data, Ram1Addr, Ram1OE, rd_if.rd_valid, snap_d, snap_a);
          end
        end
      end
      rd_if.rd_ready = 1'b1;
      @(posedge CLK); #1;
      rd_if.rd_ready = 1'b0;
      if (w == 1) begin
        checks++;
        if (Ram1Addr !== snap_a + 18'd1 || Ram1OE !== 1'b0) begin
          errors++; $display("FAIL stall_next_access: addr %h oe %b, required %h 0", Ram1Addr, Ram1OE, snap_a + 18'd1);
        end
      end
    end
    t = 0;
    while (busy && t < 50) begin @(posedge CLK); #1; t++; end
    checks++;
    if (busy || exp_q.size() != 0) begin errors++; $display("FAIL stall_end: busy %b missing %0d, required 0 0", busy, exp_q.size()); end
    rd_if.rd_ready = 1'b1;
  endtask

  task automatic test_wrap();
    int nv, nd, pl, oe, en;
    base_addr = 18'h3FFFE; base_word = 16'h0A00;
    run_burst(18'h3FFFE, 3, nv, nd, pl, oe, en);
    checks++;
    if (pl != 1 || exp_q.size() != 0) begin errors++; $display("FAIL wrap_end: pulses %0d missing %0d, required 1 0", pl, exp_q.size()); end
  endtask

  task automatic test_start_ignored();
    int t;
    base_addr = 18'h00070; base_word = 16'h0700;
    push_burst(18'h00070, 2);
    pulse_start(18'h00070, 2);
    @(posedge CLK); #1;
    pulse_start(18'h00090, 5);
    t = 0;
    while (busy && t < 50) begin @(posedge CLK); #1; t++; end
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (busy !== 1'b0 || Ram1EN !== 1'b1) begin errors++; $display("FAIL ignored_start_%0d: busy %b en %b, required 0 1", c, busy, Ram1EN); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL ignored_words: missing %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_abort();
    int t, hs0;
    base_addr = 18'h00040; base_word = 16'h0400;
    hs0 = hs_count;
    push_burst(18'h00040, 8);
    pulse_start(18'h00040, 8);
    t = 0;
    while (hs_count < hs0 + 3 && t < 100) begin @(posedge CLK); #1; t++; end
    checks++;
    if (Ram1OE !== 1'b0 || Ram1Addr !== 18'h00043) begin
      errors++; $display("FAIL abort_setup: oe %b addr %h, required 0 00043", Ram1OE, Ram1Addr);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({Ram1OE, Ram1EN, rd_if.rd_valid, busy, done} !== 5'b11000) begin
      errors++; $display("FAIL abort_state: got %b, required 11000", {Ram1OE, Ram1EN, rd_if.rd_valid, busy, done});
    end
    RST = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet_%0d: done %b busy %b, required 0 0", c, done, busy); end
    end
    checks++;
    if (exp_q.size() != 5) begin errors++; $display("FAIL abort_left: %0d words left, required 5", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_verify();
    int nv, nd, pl, oe, en;
    int exp_cnt;
    base_addr = 18'h00050; base_word = 16'h0100;
    corrupt_en = 1'b1; corrupt_addr = 18'h00054;
`ifdef READ_VERIFY_EN
    exp_cnt = 1;
`else
    exp_cnt = 0;
`endif
    run_burst(18'h00050, 8, nv, nd, pl, oe, en);
    checks++;
    if (err_flag !== (exp_cnt != 0) || err_count !== LEN_W'(exp_cnt)) begin
      errors++; $display("FAIL verify_bad: flag %b count %0d, required %0d %0d", err_flag, err_count, exp_cnt != 0, exp_cnt);
    end
    corrupt_en = 1'b0;
    base_addr = 18'h00060; base_word = 16'h0600;
    run_burst(18'h00060, 4, nv, nd, pl, oe, en);
    checks++;
    if (err_flag !== 1'b0 || err_count !== '0) begin
      errors++; $display("FAIL verify_clean: flag %b count %0d, required 0 0", err_flag, err_count);
    end
  endtask

  initial begin
    rd_if.rd_ready = 1'b1;
    test_reset();
    test_burst();
    test_zero_count();
    test_backpressure();
    test_wrap();
    test_start_ignored();
    test_reset_abort();
    test_verify();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
